// File: rtl/vga_timing_pkg.sv
// Shared types and SVGA 800x600@56Hz timing constants for the raster generator.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [3:0] rgb4_t;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 24;
    localparam int SVGA_H_SYNC   = 72;
    localparam int SVGA_H_BP     = 128;
    localparam int SVGA_H_TOTAL  = SVGA_H_ACTIVE + SVGA_H_FP + SVGA_H_SYNC + SVGA_H_BP;

    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 2;
    localparam int SVGA_V_BP     = 22;
    localparam int SVGA_V_TOTAL  = SVGA_V_ACTIVE + SVGA_V_FP + SVGA_V_SYNC + SVGA_V_BP;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate interface: game logic on one side, VGA pins on the other.
interface vga_timing_gen_if;
    import vga_timing_pkg::*;

    coord_t      h_coord;
    coord_t      v_coord;
    logic        display_on;
    logic        end_of_frame;
    logic [15:0] frame_cnt;
    rgb4_t       red_in;
    rgb4_t       green_in;
    rgb4_t       blue_in;
    logic        vga_hs;
    logic        vga_vs;
    rgb4_t       vga_r;
    rgb4_t       vga_g;
    rgb4_t       vga_b;

    // Timing generator side
    modport master (
        output h_coord, v_coord, display_on, end_of_frame, frame_cnt,
        output vga_hs, vga_vs, vga_r, vga_g, vga_b,
        input  red_in, green_in, blue_in
    );

    // Game logic / pin consumer side
    modport slave (
        input  h_coord, v_coord, display_on, end_of_frame, frame_cnt,
        input  vga_hs, vga_vs, vga_r, vga_g, vga_b,
        output red_in, green_in, blue_in
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with active-area and sync decode.
module vga_axis_counter #(
    parameter int ACTIVE = 800,
    parameter int FP     = 24,
    parameter int SYNC   = 72,
    parameter int BP     = 128,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic         wrap,
    output logic [W-1:0] cnt,
    output logic         active,
    output logic         sync
);

    localparam int           TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q, cnt_d;

    assign wrap   = en && (cnt_q == LAST);
    assign cnt    = cnt_q;
    assign active = (cnt_q < ACT_END);
    assign sync   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

    // Next position: advance when enabled, back to 0 after the last position
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    // Position register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters -> stage 1 (coords, syncs) -> stage 2 (pins).
// Game colour comes back combinationally from the stage-1 coords and is
// captured in stage 2 so it lines up with the delayed syncs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_H_ACTIVE,
    parameter int H_FP     = SVGA_H_FP,
    parameter int H_SYNC   = SVGA_H_SYNC,
    parameter int H_BP     = SVGA_H_BP,
    parameter int V_ACTIVE = SVGA_V_ACTIVE,
    parameter int V_FP     = SVGA_V_FP,
    parameter int V_SYNC   = SVGA_V_SYNC,
    parameter int V_BP     = SVGA_V_BP,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1
) (
    input  logic pixel_clk,
    input  logic rst,
    vga_timing_gen_if.master bus
);

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt;
    logic        h_wrap, h_act, h_sync;
    logic        v_act, v_sync;
    // Frame wrap is not needed: end_of_frame is timed from the stage-1 coords
    logic        v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(11)
    ) u_h (
        .clk(pixel_clk), .rst(rst), .en(1'b1),
        .wrap(h_wrap), .cnt(h_cnt), .active(h_act), .sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(10)
    ) u_v (
        .clk(pixel_clk), .rst(rst), .en(h_wrap),
        .wrap(v_wrap_unused), .cnt(v_cnt), .active(v_act), .sync(v_sync)
    );

    // Stage 1 state
    logic        disp_q, hs1_q, vs1_q;
    coord_t      hc_q, vc_q, hc_d, vc_d;
    logic        act;

    // Stage 2 state (pins)
    rgb4_t       r_q, g_q, b_q;
    logic        hs_q, vs_q;

    // Frame pacing
    logic        eof_q, eof_d;
    logic [15:0] frame_cnt_q;

    // Coordinates are forced to 0 outside the active area
    always_comb begin
        act  = h_act && v_act;
        hc_d = act ? coord_t'(h_cnt) : '0;
        vc_d = act ? coord_t'(v_cnt) : '0;
        eof_d = disp_q && (hc_q == coord_t'(H_ACTIVE - 1))
                       && (vc_q == coord_t'(V_ACTIVE - 1));
    end

    // Stage 1: coordinates, display enable and raw sync decode
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            disp_q <= 1'b0;
            hc_q   <= '0;
            vc_q   <= '0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
        end else begin
            disp_q <= act;
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            hs1_q  <= h_sync;
            vs1_q  <= v_sync;
        end
    end

    // Stage 2: blanked colour and polarity-adjusted syncs, all on the same edge
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= ~HS_POL;
            vs_q <= ~VS_POL;
        end else begin
            r_q  <= disp_q ? bus.red_in   : '0;
            g_q  <= disp_q ? bus.green_in : '0;
            b_q  <= disp_q ? bus.blue_in  : '0;
            hs_q <= hs1_q ? HS_POL : ~HS_POL;
            vs_q <= vs1_q ? VS_POL : ~VS_POL;
        end
    end

    // End-of-frame strobe follows the last active pixel; frame count rises with it
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            eof_q <= eof_d;
            if (eof_d) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.h_coord      = hc_q;
    assign bus.v_coord      = vc_q;
    assign bus.display_on   = disp_q;
    assign bus.end_of_frame = eof_q;
    assign bus.frame_cnt    = frame_cnt_q;
    assign bus.vga_r        = r_q;
    assign bus.vga_g        = g_q;
    assign bus.vga_b        = b_q;
    assign bus.vga_hs       = hs_q;
    assign bus.vga_vs       = vs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full SVGA instance for line timing/blanking/alignment, and a
// miniature active-low instance (16x8 raster) for frame timing and frame count.
module tb_vga_timing_gen;

    logic pixel_clk;
    logic rst;
    logic use_coord;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    vga_timing_gen_if bus_d ();
    vga_timing_gen_if bus_s ();

    // Game model: constant white, or colour = low bits of the column
    assign bus_d.red_in   = use_coord ? bus_d.h_coord[3:0] : 4'hF;
    assign bus_d.green_in = 4'hF;
    assign bus_d.blue_in  = 4'hF;
    assign bus_s.red_in   = 4'hA;
    assign bus_s.green_in = 4'h5;
    assign bus_s.blue_in  = 4'h3;

    vga_timing_gen u_d (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .bus(bus_d)
    );

    // 16-cycle lines (8/2/3/3), 8-line frames (4/1/2/1) -> 128 cycles per frame
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_s (
        .pixel_clk(pixel_clk),
        .rst(rst),
        .bus(bus_s)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_d_disp"},  32'(bus_d.display_on), 32'd0);
        check({tag, "_d_hc"},    32'(bus_d.h_coord), 32'd0);
        check({tag, "_d_vc"},    32'(bus_d.v_coord), 32'd0);
        check({tag, "_d_eof"},   32'(bus_d.end_of_frame), 32'd0);
        check({tag, "_d_rgb"},   32'({bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}), 32'd0);
        check({tag, "_d_syncs"}, 32'({bus_d.vga_hs, bus_d.vga_vs}), 32'b00);
        check({tag, "_s_fcnt"},  32'(bus_s.frame_cnt), 32'd0);
        check({tag, "_s_rgb"},   32'({bus_s.vga_r, bus_s.vga_g, bus_s.vga_b}), 32'd0);
        check({tag, "_s_syncs"}, 32'({bus_s.vga_hs, bus_s.vga_vs}), 32'b11);
    endtask

    initial begin
        int hs_first = -1, hs_second = -1, hs_hi = 0, disp_n = 0;
        int r_f = 0, r_z = 0;
        int s_hs_first = -1, s_hs_lo = 0, vs_first = -1, vs_lo = 0;
        int eof_t0 = -1, eof_t1 = -1, eof_n = 0;
        int align_n = 0, align_bad = 0;
        logic prev_hs = 1'b0, prev_disp = 1'b0;
        logic [3:0] prev_h = 4'h0;
        logic found;

        rst = 1'b1;
        use_coord = 1'b0;
        repeat (3) @(posedge pixel_clk);
        @(negedge pixel_clk) rst = 1'b0;
        repeat (300) @(posedge pixel_clk);

        // Asynchronous reset in the middle of a cycle
        #3 rst = 1'b1;
        #1 check_reset_state("rst_async");
        repeat (5) @(posedge pixel_clk);
        #1 check_reset_state("rst_hold");
        @(negedge pixel_clk) rst = 1'b0;
        #1 check("rel_disp0", 32'(bus_d.display_on), 32'd0);

        // k = number of rising edges since reset release
        for (int k = 1; k <= 1900; k++) begin
            @(posedge pixel_clk);
            #1;
            if (k == 1) begin
                check("first_disp", 32'(bus_d.display_on), 32'd1);
                check("first_hc",   32'(bus_d.h_coord), 32'd0);
                check("first_vc",   32'(bus_d.v_coord), 32'd0);
                check("s_hs_idle",  32'(bus_s.vga_hs), 32'd1);
                check("s_vs_idle",  32'(bus_s.vga_vs), 32'd1);
            end
            if (k == 2) check("rgb_k2", 32'({bus_d.vga_r, bus_d.vga_g, bus_d.vga_b}), 32'hFFF);
            if (k == 5) check("hc_k5", 32'(bus_d.h_coord), 32'd4);
            if (k == 802) check("r_fp_blank", 32'(bus_d.vga_r), 32'd0);
            if (k == 1024) check("blank_hc", 32'({bus_d.display_on, bus_d.h_coord}), 32'd0);
            if (k == 1025) begin
                check("line1_disp", 32'(bus_d.display_on), 32'd1);
                check("line1_vc",   32'(bus_d.v_coord), 32'd1);
                check("line1_hc",   32'(bus_d.h_coord), 32'd0);
            end

            // Default instance, first line
            if (bus_d.vga_hs && !prev_hs) begin
                if (hs_first < 0) hs_first = k;
                else if (hs_second < 0) hs_second = k;
            end
            prev_hs = bus_d.vga_hs;
            if (k <= 1024) begin
                if (bus_d.vga_hs) hs_hi++;
                if (bus_d.display_on) disp_n++;
            end
            if (k >= 2 && k <= 1025) begin
                if (bus_d.vga_r == 4'hF) r_f++;
                if (bus_d.vga_r == 4'h0) r_z++;
            end

            // Pixel alignment once the coordinate-driven colour is in the pipe
            if (k >= 1102) begin
                if (prev_disp) begin
                    align_n++;
                    if (bus_d.vga_r !== prev_h) align_bad++;
                end else if (bus_d.vga_r !== 4'h0) begin
                    align_bad++;
                end
            end
            prev_disp = bus_d.display_on;
            prev_h    = bus_d.h_coord[3:0];
            if (k == 1100) use_coord = 1'b1;

            // Miniature instance
            if (k <= 16 && !bus_s.vga_hs) begin
                s_hs_lo++;
                if (s_hs_first < 0) s_hs_first = k;
            end
            if (k <= 128 && !bus_s.vga_vs) begin
                vs_lo++;
                if (vs_first < 0) vs_first = k;
            end
            if (bus_s.end_of_frame) begin
                if (k <= 128) eof_n++;
                if (eof_t0 < 0) eof_t0 = k;
                else if (eof_t1 < 0) eof_t1 = k;
            end
            if (k == 56)  check("fcnt_pre",  32'(bus_s.frame_cnt), 32'd0);
            if (k == 57)  check("fcnt_one",  32'(bus_s.frame_cnt), 32'd1);
            if (k == 185) check("fcnt_two",  32'(bus_s.frame_cnt), 32'd2);
        end

        check("hs_rise",      32'(hs_first), 32'd826);
        check("hs_period",    32'(hs_second - hs_first), 32'd1024);
        check("hs_width",     32'(hs_hi), 32'd72);
        check("disp_per_ln",  32'(disp_n), 32'd800);
        check("rgb_white_n",  32'(r_f), 32'd800);
        check("rgb_zero_n",   32'(r_z), 32'd224);
        check("align_n",      32'(align_n), 32'd724);
        check("align_bad",    32'(align_bad), 32'd0);
        check("s_hs_first",   32'(s_hs_first), 32'd12);
        check("s_hs_width",   32'(s_hs_lo), 32'd3);
        check("s_vs_first",   32'(vs_first), 32'd82);
        check("s_vs_width",   32'(vs_lo), 32'd32);
        check("eof_first",    32'(eof_t0), 32'd57);
        check("eof_period",   32'(eof_t1 - eof_t0), 32'd128);
        check("eof_once",     32'(eof_n), 32'd1);
        check("fcnt_k1900",   32'(bus_s.frame_cnt), 32'd15);

        // Frame counter wrap: preload FFFF well away from a frame boundary
        force u_s.frame_cnt_q = 16'hFFFF;
        @(negedge pixel_clk);
        release u_s.frame_cnt_q;
        #1 check("fcnt_forced", 32'(bus_s.frame_cnt), 32'hFFFF);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge pixel_clk);
            #1;
            if (bus_s.end_of_frame) found = 1'b1;
        end
        check("wrap_eof_seen", 32'(found), 32'd1);
        check("fcnt_wrap",     32'(bus_s.frame_cnt), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
